aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_gcm_pkg.sv | 64 ++++++
 rtl/aes_sub_word.sv | 20 ++
 rtl/aes_key_sched.sv | 122 ++++++++++++
 tb/tb_aes_key_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gcm_pkg.sv
// Shared AES-GCM definitions: key-schedule geometry defaults, the AES
// S-box, the round-constant table and the key-schedule state encoding.
// No ports; imported by aes_sub_word and aes_key_sched.
package aes_gcm_pkg;

    localparam int AES_RND_SIZE = 128;
    localparam int AES_WRD_SIZE = 32;
    localparam int AES_NUM_BLK  = 4;

    // Index of the final AES-128 round key
    localparam logic [3:0] AES_LAST_IDX = 4'd10;

    typedef enum logic {
        IDLE,
        EXPAND
    } ks_state_e;

    // Forward S-box, byte 0x00 in the most significant position
    localparam logic [2047:0] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Shift the wanted entry to the top byte rather than computing a
    // variable part-select index
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [2047:0] shifted;
        shifted  = AES_SBOX << {b, 3'b000};
        aes_sbox = shifted[2047:2040];
    endfunction

    // Round constants for rounds 1..10; anything else yields zero so an
    // out-of-range index can never inject a constant
    function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    aes_rcon = 8'h01;
            4'd2:    aes_rcon = 8'h02;
            4'd3:    aes_rcon = 8'h04;
            4'd4:    aes_rcon = 8'h08;
            4'd5:    aes_rcon = 8'h10;
            4'd6:    aes_rcon = 8'h20;
            4'd7:    aes_rcon = 8'h40;
            4'd8:    aes_rcon = 8'h80;
            4'd9:    aes_rcon = 8'h1b;
            4'd10:   aes_rcon = 8'h36;
            default: aes_rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely
// combinational. Uses the same S-box as the round SubBytes stage.
// Ports:
//   word_i  input  [31:0]  word to substitute
//   word_o  output [31:0]  byte-wise S-box result
module aes_sub_word
    import aes_gcm_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < 4; i++) begin
            word_o[i*8 +: 8] = aes_sbox(word_i[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key schedule producing one round key per handshake.
// A key accepted in IDLE is presented as round key 0 the next cycle; each
// consumer handshake replaces it with the next round key until round 10
// has been taken, after which the block returns to IDLE.
// Ports:
//   clk        input   clock, all state on rising edge
//   rst_n      input   asynchronous active-low reset
//   i_key      input   cipher key, word 0 in the top 32 bits
//   i_key_vld  input   i_key valid
//   o_key_rdy  output  new key can be accepted
//   o_rnd_key  output  current round key
//   o_rnd_idx  output  index of o_rnd_key, 0..10
//   o_rnd_vld  output  o_rnd_key valid
//   i_rnd_rdy  input   consumer takes o_rnd_key this cycle
//   o_lst_rnd  output  o_rnd_key is round key 10
module aes_key_sched
    import aes_gcm_pkg::*;
#(
    parameter int RND_SIZE = AES_RND_SIZE,
    parameter int WRD_SIZE = AES_WRD_SIZE,
    parameter int NUM_BLK  = AES_NUM_BLK
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RND_SIZE-1:0] i_key,
    input  logic                i_key_vld,
    output logic                o_key_rdy,
    output logic [RND_SIZE-1:0] o_rnd_key,
    output logic [3:0]          o_rnd_idx,
    output logic                o_rnd_vld,
    input  logic                i_rnd_rdy,
    output logic                o_lst_rnd
);

    ks_state_e           state_q;
    logic [RND_SIZE-1:0] key_q;
    logic [RND_SIZE-1:0] key_d;
    logic [3:0]          idx_q;
    logic                vld_q;
    logic                rdy_q;
    logic                lst_q;

    logic [WRD_SIZE-1:0] lastWord;
    logic [WRD_SIZE-1:0] rotWord;
    logic [WRD_SIZE-1:0] subWord;
    logic [WRD_SIZE-1:0] tWord;

    assign lastWord = key_q[WRD_SIZE-1:0];
    assign rotWord  = {lastWord[WRD_SIZE-9:0], lastWord[WRD_SIZE-1 -: 8]};

    aes_sub_word u_sub_word (
        .word_i (rotWord),
        .word_o (subWord)
    );

    assign tWord = subWord ^ {aes_rcon(idx_q + 4'd1), {(WRD_SIZE-8){1'b0}}};

    // Each new word is the old word XOR the previously produced new word,
    // with t seeding the chain for word 0
    always_comb begin
        logic [WRD_SIZE-1:0] carry;
        key_d = '0;
        carry = tWord;
        for (int i = 0; i < NUM_BLK; i++) begin
            carry = carry ^ key_q[RND_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
            key_d[RND_SIZE-1-i*WRD_SIZE -: WRD_SIZE] = carry;
        end
    end

    // o_lst_rnd is registered alongside the index so it changes on the
    // same edge that o_rnd_idx reaches 10
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            lst_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_key_vld) begin
                        key_q   <= i_key;
                        idx_q   <= 4'd0;
                        vld_q   <= 1'b1;
                        rdy_q   <= 1'b0;
                        lst_q   <= 1'b0;
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (vld_q && i_rnd_rdy) begin
                        if (idx_q == AES_LAST_IDX) begin
                            vld_q   <= 1'b0;
                            rdy_q   <= 1'b1;
                            lst_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            key_q <= key_d;
                            idx_q <= idx_q + 4'd1;
                            lst_q <= (idx_q == AES_LAST_IDX - 4'd1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    lst_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_key_rdy = rdy_q;
    assign o_rnd_key = key_q;
    assign o_rnd_idx = idx_q;
    assign o_rnd_vld = vld_q;
    assign o_lst_rnd = lst_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched;

    logic         clk;
    logic         rst_n;
    logic [127:0] i_key;
    logic         i_key_vld;
    logic         o_key_rdy;
    logic [127:0] o_rnd_key;
    logic [3:0]   o_rnd_idx;
    logic         o_rnd_vld;
    logic         i_rnd_rdy;
    logic         o_lst_rnd;

    int checks;
    int failures;

    logic [127:0] fipsKeys [0:10];
    logic [127:0] zeroIdx1;
    logic [127:0] zeroIdx10;

    aes_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key     (i_key),
        .i_key_vld (i_key_vld),
        .o_key_rdy (o_key_rdy),
        .o_rnd_key (o_rnd_key),
        .o_rnd_idx (o_rnd_idx),
        .o_rnd_vld (o_rnd_vld),
        .i_rnd_rdy (i_rnd_rdy),
        .o_lst_rnd (o_lst_rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a key for one edge; returns at the negedge after acceptance
    task applyStimulus(input logic [127:0] k);
        @(negedge clk);
        i_key     = k;
        i_key_vld = 1'b1;
        @(negedge clk);
        i_key_vld = 1'b0;
    endtask

    task test_reset;
        checks++;
        if (o_key_rdy !== 1'b1 || o_rnd_vld !== 1'b0 || o_lst_rnd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: rdy=%b vld=%b lst=%b expected rdy=1 vld=0 lst=0", o_key_rdy, o_rnd_vld, o_lst_rnd);
        end
        checks++;
        if (o_rnd_key !== 128'h0 || o_rnd_idx !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_key_idx: key=%h idx=%0d expected key=0 idx=0", o_rnd_key, o_rnd_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_key_rdy !== 1'b1 || o_rnd_vld !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_release: rdy=%b vld=%b expected rdy=1 vld=0", o_key_rdy, o_rnd_vld);
        end
    endtask

    task test_fips_continuous;
        int validCount;
        validCount = 0;
        i_rnd_rdy  = 1'b1;
        applyStimulus(fipsKeys[0]);
        checks++;
        if (o_key_rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL expand_rdy: rdy=%b expected 0", o_key_rdy);
        end
        for (int n = 0; n <= 10; n++) begin
            if (o_rnd_vld === 1'b1) validCount++;
            checks++;
            if (o_rnd_vld !== 1'b1 || o_rnd_idx !== n[3:0] || o_rnd_key !== fipsKeys[n] || o_lst_rnd !== (n == 10)) begin
                failures++;
                $display("[TB] FAIL fips_round%0d: vld=%b idx=%0d key=%h lst=%b expected vld=1 idx=%0d key=%h lst=%b",
                         n, o_rnd_vld, o_rnd_idx, o_rnd_key, o_lst_rnd, n, fipsKeys[n], (n == 10));
            end
            @(negedge clk);
        end
        checks++;
        if (validCount != 11) begin
            failures++;
            $display("[TB] FAIL fips_valid_count: got %0d expected 11", validCount);
        end
        checks++;
        if (o_rnd_vld !== 1'b0 || o_key_rdy !== 1'b1 || o_lst_rnd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fips_return_idle: vld=%b rdy=%b lst=%b expected vld=0 rdy=1 lst=0", o_rnd_vld, o_key_rdy, o_lst_rnd);
        end
    endtask

    task test_zero_key;
        i_rnd_rdy = 1'b1;
        applyStimulus(128'h0);
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (o_rnd_vld !== 1'b1 || o_rnd_idx !== n[3:0]) begin
                failures++;
                $display("[TB] FAIL zero_idx%0d: vld=%b idx=%0d expected vld=1 idx=%0d", n, o_rnd_vld, o_rnd_idx, n);
            end
            if (n == 1) begin
                checks++;
                if (o_rnd_key !== zeroIdx1) begin
                    failures++;
                    $display("[TB] FAIL zero_key1: got %h expected %h", o_rnd_key, zeroIdx1);
                end
            end
            if (n == 10) begin
                checks++;
                if (o_rnd_key !== zeroIdx10 || o_lst_rnd !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL zero_key10: got %h lst=%b expected %h lst=1", o_rnd_key, o_lst_rnd, zeroIdx10);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (o_rnd_vld !== 1'b0 || o_key_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_return_idle: vld=%b rdy=%b expected vld=0 rdy=1", o_rnd_vld, o_key_rdy);
        end
    endtask

    task test_backpressure;
        i_rnd_rdy = 1'b1;
        applyStimulus(fipsKeys[0]);
        repeat (4) @(negedge clk);
        i_rnd_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o_rnd_vld !== 1'b1 || o_rnd_idx !== 4'd4 || o_rnd_key !== fipsKeys[4] || o_lst_rnd !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_cycle%0d: vld=%b idx=%0d key=%h lst=%b expected vld=1 idx=4 key=%h lst=0",
                         c, o_rnd_vld, o_rnd_idx, o_rnd_key, o_lst_rnd, fipsKeys[4]);
            end
        end
        i_rnd_rdy = 1'b1;
        for (int n = 4; n <= 10; n++) begin
            checks++;
            if (o_rnd_vld !== 1'b1 || o_rnd_idx !== n[3:0] || o_rnd_key !== fipsKeys[n] || o_lst_rnd !== (n == 10)) begin
                failures++;
                $display("[TB] FAIL resume_round%0d: vld=%b idx=%0d key=%h lst=%b expected idx=%0d key=%h",
                         n, o_rnd_vld, o_rnd_idx, o_rnd_key, o_lst_rnd, n, fipsKeys[n]);
            end
            @(negedge clk);
        end
        checks++;
        if (o_rnd_vld !== 1'b0 || o_key_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL resume_return_idle: vld=%b rdy=%b expected vld=0 rdy=1", o_rnd_vld, o_key_rdy);
        end
    endtask

    task test_reset_mid;
        i_rnd_rdy = 1'b1;
        applyStimulus(fipsKeys[0]);
        repeat (6) @(negedge clk);
        checks++;
        if (o_rnd_idx !== 4'd6 || o_rnd_key !== fipsKeys[6]) begin
            failures++;
            $display("[TB] FAIL pre_reset_idx6: idx=%0d key=%h expected idx=6 key=%h", o_rnd_idx, o_rnd_key, fipsKeys[6]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_rnd_vld !== 1'b0 || o_key_rdy !== 1'b1 || o_rnd_idx !== 4'd0 || o_rnd_key !== 128'h0 || o_lst_rnd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: vld=%b rdy=%b idx=%0d key=%h lst=%b expected vld=0 rdy=1 idx=0 key=0 lst=0",
                     o_rnd_vld, o_key_rdy, o_rnd_idx, o_rnd_key, o_lst_rnd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_rnd_vld !== 1'b0 || o_key_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: vld=%b rdy=%b expected vld=0 rdy=1", o_rnd_vld, o_key_rdy);
        end
        applyStimulus(fipsKeys[0]);
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (o_rnd_vld !== 1'b1 || o_rnd_idx !== n[3:0] || o_rnd_key !== fipsKeys[n]) begin
                failures++;
                $display("[TB] FAIL post_reset_round%0d: vld=%b idx=%0d key=%h expected idx=%0d key=%h",
                         n, o_rnd_vld, o_rnd_idx, o_rnd_key, n, fipsKeys[n]);
            end
            @(negedge clk);
        end
    endtask

    task test_ignore_key;
        i_rnd_rdy = 1'b1;
        applyStimulus(fipsKeys[0]);
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (o_rnd_idx !== n[3:0] || o_rnd_key !== fipsKeys[n]) begin
                failures++;
                $display("[TB] FAIL ignore_round%0d: idx=%0d key=%h expected idx=%0d key=%h",
                         n, o_rnd_idx, o_rnd_key, n, fipsKeys[n]);
            end
            if (n == 2) begin
                i_key     = 128'h0;
                i_key_vld = 1'b1;
            end else begin
                i_key_vld = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (o_rnd_vld !== 1'b0 || o_key_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ignore_return_idle: vld=%b rdy=%b expected vld=0 rdy=1", o_rnd_vld, o_key_rdy);
        end
        i_key     = 128'h0;
        i_key_vld = 1'b1;
        @(negedge clk);
        i_key_vld = 1'b0;
        checks++;
        if (o_rnd_vld !== 1'b1 || o_rnd_idx !== 4'd0 || o_rnd_key !== 128'h0) begin
            failures++;
            $display("[TB] FAIL new_key_latency: vld=%b idx=%0d key=%h expected vld=1 idx=0 key=0", o_rnd_vld, o_rnd_idx, o_rnd_key);
        end
        @(negedge clk);
        checks++;
        if (o_rnd_idx !== 4'd1 || o_rnd_key !== zeroIdx1) begin
            failures++;
            $display("[TB] FAIL new_key_round1: idx=%0d key=%h expected idx=1 key=%h", o_rnd_idx, o_rnd_key, zeroIdx1);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (o_rnd_vld !== 1'b0 || o_key_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL new_key_done: vld=%b rdy=%b expected vld=0 rdy=1", o_rnd_vld, o_key_rdy);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        i_key     = '0;
        i_key_vld = 1'b0;
        i_rnd_rdy = 1'b0;

        fipsKeys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fipsKeys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fipsKeys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fipsKeys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fipsKeys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fipsKeys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fipsKeys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fipsKeys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fipsKeys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fipsKeys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fipsKeys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zeroIdx1     = 128'h62636363626363636263636362636363;
        zeroIdx10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        #12;
        test_reset();
        test_fips_continuous();
        test_zero_key();
        test_backpressure();
        test_reset_mid();
        test_ignore_key();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
